// File: rtl/crop_pkg.sv
// Shared defaults, width helper and the output beat layout for the multi-window crop.
package crop_pkg;

  localparam int DEF_PIXEL_BIT_WIDTH = 8;
  localparam int DEF_CHANNELS        = 1;
  localparam int DEF_IN_ROWS         = 9;
  localparam int DEF_IN_COLS         = 9;
  localparam int DEF_OUT_ROWS        = 3;
  localparam int DEF_OUT_COLS        = 3;
  localparam int DEF_NUM_CROPS       = 2;
  localparam int DEF_FIFO_DEPTH      = 8;

  // Index width that never collapses to zero bits for a single entry.
  function automatic int idx_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  localparam int DEF_PW = DEF_CHANNELS * DEF_PIXEL_BIT_WIDTH;
  localparam int DEF_IW = idx_width(DEF_NUM_CROPS);

  typedef struct packed {
    logic [DEF_PW-1:0] pixel;
    logic [DEF_IW-1:0] idx;
    logic              last;
  } crop_beat_t;

endpackage

// File: rtl/sync_fifo.sv
// Ready/valid FIFO; a push into a full FIFO is accepted when a pop happens in the same cycle.
module sync_fifo import crop_pkg::*; #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] in_data,
  input  logic             in_valid,
  output logic             in_ready,
  output logic [WIDTH-1:0] out_data,
  output logic             out_valid,
  input  logic             out_ready
);

  localparam int AW = idx_width(DEPTH);
  localparam logic [AW:0]   FULL_CNT = (AW+1)'(DEPTH);
  localparam logic [AW:0]   CNT_ONE  = (AW+1)'(1);
  localparam logic [AW-1:0] PTR_ONE  = AW'(1);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] mem_d [DEPTH];
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [AW:0]      count_q, count_d;
  logic             push, pop;

  always_comb begin
    out_valid = (count_q != '0);
    out_data  = out_valid ? mem_q[rd_ptr_q] : '0;
    pop       = out_valid && out_ready;
    in_ready  = (count_q != FULL_CNT) || pop;
    push      = in_valid && in_ready;
    mem_d     = mem_q;
    wr_ptr_d  = wr_ptr_q;
    rd_ptr_d  = rd_ptr_q;
    count_d   = count_q;
    if (push) begin
      mem_d[wr_ptr_q] = in_data;
      wr_ptr_d        = wr_ptr_q + PTR_ONE;
    end
    if (pop) rd_ptr_d = rd_ptr_q + PTR_ONE;
    case ({push, pop})
      2'b10:   count_d = count_q + CNT_ONE;
      2'b01:   count_d = count_q - CNT_ONE;
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mem_q    <= '{default: '0};
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      mem_q    <= mem_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

endmodule

// File: rtl/multi_crop_fifo.sv
// Streaming multi-window crop: per-pixel hit mask against per-frame window origins, one FIFO
// beat per hit crop in ascending crop index.
module multi_crop_fifo import crop_pkg::*; #(
  parameter int PIXEL_BIT_WIDTH = DEF_PIXEL_BIT_WIDTH,
  parameter int CHANNELS        = DEF_CHANNELS,
  parameter int IN_ROWS         = DEF_IN_ROWS,
  parameter int IN_COLS         = DEF_IN_COLS,
  parameter int OUT_ROWS        = DEF_OUT_ROWS,
  parameter int OUT_COLS        = DEF_OUT_COLS,
  parameter int NUM_CROPS       = DEF_NUM_CROPS,
  parameter int FIFO_DEPTH      = DEF_FIFO_DEPTH,
  localparam int PW = CHANNELS * PIXEL_BIT_WIDTH,
  localparam int RW = $clog2(IN_ROWS),
  localparam int CW = $clog2(IN_COLS),
  localparam int IW = idx_width(NUM_CROPS)
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [PW-1:0]         pixel_in,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [NUM_CROPS*RW-1:0] crop_y,
  input  logic [NUM_CROPS*CW-1:0] crop_x,
  output logic [PW-1:0]         pixel_out,
  output logic [IW-1:0]         out_crop_idx,
  output logic                  out_last,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic                  frame_done
);

  localparam int BW = PW + IW + 1;
  localparam logic [NUM_CROPS-1:0] MASK_ONE = NUM_CROPS'(1);

  logic [RW-1:0]           row_q, row_d;
  logic [CW-1:0]           col_q, col_d;
  logic [NUM_CROPS*RW-1:0] cy_q, cy_d, cy_eff;
  logic [NUM_CROPS*CW-1:0] cx_q, cx_d, cx_eff;
  logic [PW-1:0]           hold_pix_q, hold_pix_d;
  logic [NUM_CROPS-1:0]    hold_mask_q, hold_mask_d, hold_last_q, hold_last_d;
  logic [NUM_CROPS-1:0]    hit_mask, last_mask, sel;
  logic [IW-1:0]           sel_idx;
  logic                    run_q, run_d, frame_done_q, frame_done_d;
  logic                    frame_start, push_valid, push, accept, single_bit;
  logic                    fifo_in_ready;
  logic [BW-1:0]           fifo_in_data, fifo_out_data;
  int                      yk, xk, r, c;

  // Pixel (0,0) must already see the new origins, so it compares against the live inputs.
  always_comb begin
    frame_start = (row_q == '0) && (col_q == '0);
    cy_eff      = frame_start ? crop_y : cy_q;
    cx_eff      = frame_start ? crop_x : cx_q;
    hit_mask    = '0;
    last_mask   = '0;
    yk = 0;
    xk = 0;
    r  = int'(row_q);
    c  = int'(col_q);
    for (int k = 0; k < NUM_CROPS; k++) begin
      yk = int'(cy_eff[k*RW +: RW]);
      xk = int'(cx_eff[k*CW +: CW]);
      hit_mask[k]  = (yk + OUT_ROWS <= IN_ROWS) && (xk + OUT_COLS <= IN_COLS) &&
                     (r >= yk) && (r < yk + OUT_ROWS) && (c >= xk) && (c < xk + OUT_COLS);
      last_mask[k] = (r == yk + OUT_ROWS - 1) && (c == xk + OUT_COLS - 1);
    end
  end

  always_comb begin
    sel     = hold_mask_q & (~hold_mask_q + MASK_ONE);
    sel_idx = '0;
    for (int k = NUM_CROPS - 1; k >= 0; k--) begin
      if (hold_mask_q[k]) sel_idx = IW'(k);
    end
    push_valid   = (hold_mask_q != '0);
    single_bit   = ((hold_mask_q & (hold_mask_q - MASK_ONE)) == '0);
    push         = push_valid && fifo_in_ready;
    fifo_in_data = {hold_pix_q, sel_idx, |(sel & hold_last_q)};
    // An empty mask never occupies the hold stage, so non-hit pixels stream at full rate.
    in_ready     = run_q && (!push_valid || (single_bit && fifo_in_ready));
    accept       = in_valid && in_ready;

    run_d        = 1'b1;
    row_d        = row_q;
    col_d        = col_q;
    cy_d         = cy_q;
    cx_d         = cx_q;
    hold_pix_d   = hold_pix_q;
    hold_mask_d  = hold_mask_q;
    hold_last_d  = hold_last_q;
    frame_done_d = 1'b0;

    if (push) hold_mask_d = hold_mask_q & ~sel;
    if (accept) begin
      hold_pix_d  = pixel_in;
      hold_mask_d = hit_mask;
      hold_last_d = last_mask;
      if (frame_start) begin
        cy_d = crop_y;
        cx_d = crop_x;
      end
      if (col_q == CW'(IN_COLS - 1)) begin
        col_d = '0;
        if (row_q == RW'(IN_ROWS - 1)) begin
          row_d        = '0;
          frame_done_d = 1'b1;
        end else begin
          row_d = row_q + RW'(1);
        end
      end else begin
        col_d = col_q + CW'(1);
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      run_q        <= 1'b0;
      row_q        <= '0;
      col_q        <= '0;
      cy_q         <= '0;
      cx_q         <= '0;
      hold_pix_q   <= '0;
      hold_mask_q  <= '0;
      hold_last_q  <= '0;
      frame_done_q <= 1'b0;
    end else begin
      run_q        <= run_d;
      row_q        <= row_d;
      col_q        <= col_d;
      cy_q         <= cy_d;
      cx_q         <= cx_d;
      hold_pix_q   <= hold_pix_d;
      hold_mask_q  <= hold_mask_d;
      hold_last_q  <= hold_last_d;
      frame_done_q <= frame_done_d;
    end
  end

  sync_fifo #(
    .WIDTH (BW),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk       (clk),
    .rst       (reset),
    .in_data   (fifo_in_data),
    .in_valid  (push_valid),
    .in_ready  (fifo_in_ready),
    .out_data  (fifo_out_data),
    .out_valid (out_valid),
    .out_ready (out_ready)
  );

  assign {pixel_out, out_crop_idx, out_last} = fifo_out_data;
  assign frame_done = frame_done_q;

endmodule

// File: tb/tb_multi_crop_fifo.sv
// Directed bench for multi_crop_fifo on 9x9 frames of raster-index pixels with 3x3 windows.
module tb_multi_crop_fifo;
  import crop_pkg::*;

  localparam int PW = 8;
  localparam int RW = 4;
  localparam int CW = 4;
  localparam int IW = 1;
  localparam int BW = $bits(crop_beat_t);

  logic          clk = 1'b0;
  logic          reset;
  logic [PW-1:0] pixel_in;
  logic          in_valid;
  logic          in_ready;
  logic [2*RW-1:0] crop_y;
  logic [2*CW-1:0] crop_x;
  logic [PW-1:0] pixel_out;
  logic [IW-1:0] out_crop_idx;
  logic          out_last;
  logic          out_valid;
  logic          out_ready;
  logic          frame_done;

  always #5 clk = ~clk;

  multi_crop_fifo dut (
    .clk          (clk),
    .reset        (reset),
    .pixel_in     (pixel_in),
    .in_valid     (in_valid),
    .in_ready     (in_ready),
    .crop_y       (crop_y),
    .crop_x       (crop_x),
    .pixel_out    (pixel_out),
    .out_crop_idx (out_crop_idx),
    .out_last     (out_last),
    .out_valid    (out_valid),
    .out_ready    (out_ready),
    .frame_done   (frame_done)
  );

  logic [BW-1:0] exp_q[$];
  logic [BW-1:0] obs_q[$];
  int n_pass = 0;
  int n_total = 0;
  int n_fail = 0;
  int fd_cnt = 0;
  int stall_cnt = 0;
  int pix_idx = 0;
  int pix_end = 0;
  int cy0[64], cx0[64], cy1[64], cx1[64];

  // Transfers are decided at the next posedge; inputs and outputs are settled here.
  always @(negedge clk) begin
    #2;
    if (!reset) begin
      if (out_valid && out_ready) obs_q.push_back({pixel_out, out_crop_idx, out_last});
      if (frame_done) fd_cnt++;
      if (in_valid && !in_ready) stall_cnt++;
    end
  end

  initial begin
    #5ms;
    $display("FAIL watchdog: time limit reached, got no summary expected summary");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] want);
    n_total++;
    assert (got === want) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: got %0h expected %0h", tag, got, want);
    end
  endtask

  task automatic chk_idle_outputs(input string tag);
    chk({tag, "_out_valid"}, 32'(out_valid), 0);
    chk({tag, "_in_ready"}, 32'(in_ready), 0);
    chk({tag, "_pixel_out"}, 32'(pixel_out), 0);
    chk({tag, "_crop_idx"}, 32'(out_crop_idx), 0);
    chk({tag, "_out_last"}, 32'(out_last), 0);
    chk({tag, "_frame_done"}, 32'(frame_done), 0);
  endtask

  task automatic set_cfg(input int f, input int y0, input int x0, input int y1, input int x1);
    cy0[f] = y0; cx0[f] = x0; cy1[f] = y1; cx1[f] = x1;
  endtask

  task automatic push_exp(input int p, input int k, input int l);
    exp_q.push_back({8'(p), 1'(k), 1'(l)});
  endtask

  // Reference model: raster order, crops in ascending index within each pixel.
  task automatic expect_frame(input int f);
    int y, x;
    for (int r = 0; r < 9; r++)
      for (int c = 0; c < 9; c++)
        for (int k = 0; k < 2; k++) begin
          y = (k == 0) ? cy0[f] : cy1[f];
          x = (k == 0) ? cx0[f] : cx1[f];
          if (y + 3 <= 9 && x + 3 <= 9 && r >= y && r < y + 3 && c >= x && c < x + 3)
            push_exp(r * 9 + c, k, int'(r == y + 2 && c == x + 2));
        end
  endtask

  // One cycle: drive at negedge, sample in_ready after settling, count the accept at posedge.
  // Origins are valid only at pixel (0,0); elsewhere they carry junk.
  task automatic step(input int vp, input int rp);
    int f;
    logic acc;
    @(negedge clk);
    f = pix_idx / 81;
    in_valid = (pix_idx < pix_end) && ($urandom_range(99) < vp);
    pixel_in = 8'(pix_idx % 81);
    if (pix_idx % 81 == 0) begin
      crop_y = {4'(cy1[f]), 4'(cy0[f])};
      crop_x = {4'(cx1[f]), 4'(cx0[f])};
    end else begin
      crop_y = 8'($urandom);
      crop_x = 8'($urandom);
    end
    out_ready = ($urandom_range(99) < rp);
    #1;
    acc = in_valid && in_ready;
    @(posedge clk);
    if (acc) pix_idx++;
  endtask

  task automatic send_rest(input int vp, input int rp, input string tag);
    int g = 0;
    while (pix_idx < pix_end && g < 20000) begin
      step(vp, rp);
      g++;
    end
    chk({tag, "_sent"}, pix_idx, pix_end);
  endtask

  task automatic drain_and_check(input string tag);
    int g = 0;
    int n;
    while ((obs_q.size() < exp_q.size() || out_valid) && g < 600) begin
      step(0, 100);
      g++;
    end
    repeat (4) step(0, 100);
    chk({tag, "_beats"}, obs_q.size(), exp_q.size());
    n = (obs_q.size() < exp_q.size()) ? obs_q.size() : exp_q.size();
    for (int i = 0; i < n; i++)
      chk($sformatf("%s_beat%0d", tag, i), 32'(obs_q[i]), 32'(exp_q[i]));
    obs_q.delete();
    exp_q.delete();
  endtask

  task automatic run_frames(input int n, input int vp, input int rp, input string tag);
    int fd0;
    fd0 = fd_cnt;
    pix_end = pix_idx + 81 * n;
    send_rest(vp, rp, tag);
    drain_and_check(tag);
    chk({tag, "_frame_done"}, fd_cnt - fd0, n);
  endtask

  initial begin
    int st0, base;
    reset = 1'b1; in_valid = 1'b0; pixel_in = '0; crop_y = '0; crop_x = '0; out_ready = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk); #1;
    chk_idle_outputs("reset");
    reset = 1'b0;
    repeat (2) @(posedge clk);

    // Single window at (2,2); crop 1 parked out of range.
    set_cfg(0, 2, 2, 8, 8);
    foreach (exp_q[i]) exp_q.delete(i);
    push_exp(20, 0, 0); push_exp(21, 0, 0); push_exp(22, 0, 0);
    push_exp(29, 0, 0); push_exp(30, 0, 0); push_exp(31, 0, 0);
    push_exp(38, 0, 0); push_exp(39, 0, 0); push_exp(40, 0, 1);
    st0 = stall_cnt;
    run_frames(1, 100, 100, "s1");
    chk("s1_stalls", stall_cnt - st0, 0);

    // Overlapping windows (0,0) and (1,1).
    set_cfg(1, 0, 0, 1, 1);
    push_exp(0, 0, 0);  push_exp(1, 0, 0);  push_exp(2, 0, 0);
    push_exp(9, 0, 0);  push_exp(10, 0, 0); push_exp(10, 1, 0);
    push_exp(11, 0, 0); push_exp(11, 1, 0); push_exp(12, 1, 0);
    push_exp(18, 0, 0); push_exp(19, 0, 0); push_exp(19, 1, 0);
    push_exp(20, 0, 1); push_exp(20, 1, 0); push_exp(21, 1, 0);
    push_exp(28, 1, 0); push_exp(29, 1, 0); push_exp(30, 1, 1);
    st0 = stall_cnt;
    run_frames(1, 100, 100, "s2");
    chk("s2_stalls", stall_cnt - st0, 4);

    // Output blocked: FIFO fills with 8 beats, pixel 20 waits in the hold stage.
    set_cfg(2, 0, 0, 8, 8);
    expect_frame(2);
    base = pix_idx;
    pix_end = pix_idx + 81;
    repeat (162) step(100, 0);
    #1;
    chk("s3_accepted", pix_idx - base, 21);
    chk("s3_in_ready", 32'(in_ready), 0);
    chk("s3_out_valid", 32'(out_valid), 1);
    chk("s3_head_pixel", 32'(pixel_out), 0);
    chk("s3_no_pops", obs_q.size(), 0);
    send_rest(100, 100, "s3");
    drain_and_check("s3");

    // Crop 1 at (7,0) overruns the frame and must stay silent.
    set_cfg(3, 2, 2, 7, 0);
    expect_frame(3);
    run_frames(1, 100, 100, "s4");

    // Reset 40 pixels into a frame, then a fresh frame with new origins.
    set_cfg(4, 2, 2, 0, 5);
    base = pix_idx;
    pix_end = pix_idx + 81;
    while (pix_idx < base + 40 && pix_idx < pix_end) step(100, 100);
    #1 reset = 1'b1;
    @(negedge clk); #2;
    chk_idle_outputs("s5_reset");
    repeat (2) @(posedge clk);
    obs_q.delete();
    exp_q.delete();
    pix_idx = base + 81;
    set_cfg(5, 6, 6, 0, 3);
    expect_frame(5);
    @(negedge clk) reset = 1'b0;
    @(posedge clk);
    run_frames(1, 100, 100, "s5");

    // Random handshakes with per-frame random origins, some out of range.
    for (int f = 6; f < 18; f++) begin
      set_cfg(f, $urandom_range(0, 9), $urandom_range(0, 9),
              $urandom_range(0, 9), $urandom_range(0, 9));
      expect_frame(f);
    end
    run_frames(12, 70, 60, "s6");

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
